// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and constants for the unified memory-port arbiter.
// Rev    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int LAT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : arb_pick
// Brief  : Combinational owner selection; MEM_PORT_ARB_FAIR_EN selects
//          round-robin tie breaking instead of fixed data priority.
// Rev    : 1.0
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   flush,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t owner
);

    logic if_ok;

    // A fetch raised in the same cycle as a redirect is stale.
    assign if_ok       = if_req & ~flush;
    assign grant_valid = d_req | if_ok;

`ifdef MEM_PORT_ARB_FAIR_EN
    always_comb begin
        owner = d_req ? OWN_D : OWN_IF;
        if (d_req && if_ok) begin
            owner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        owner = d_req ? OWN_D : OWN_IF;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arb
// Brief  : Shares one multicycle memory port between fetch and data access,
//          with fetch cancellation on flush. Option: MEM_PORT_ARB_FAIR_EN.
// Rev    : 1.0
// ============================================================================
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    owner_t               last_owner_q, last_owner_d;
    logic                 killed_q, killed_d;
    logic                 wr_q, wr_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 if_ack_q, if_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
    logic                 busy_q, busy_d;

    logic                 grant_valid;
    owner_t               grant_owner;

    arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .flush       (flush),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .owner       (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        killed_d     = killed_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        mem_en_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        // A redirect kills the fetch but the memory access runs to completion.
        if (state_q != IDLE && owner_q == OWN_IF && flush) begin
            killed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (grant_valid) begin
                    state_d      = ISSUE;
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    mem_en_d     = 1'b1;
                    if (grant_owner == OWN_D) begin
                        wr_d        = d_wr;
                        mem_wr_d    = d_wr;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        wr_d        = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_D) begin
                        d_ack_d = 1'b1;
                        if (!wr_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else if (!killed_d) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_D;
            killed_q     <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            killed_q     <= killed_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire
